mod_n_tcounter: RTL and testbench
=================================

MOD_N_TCOUNTER -- requirements
Module: mod_n_tcounter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..8.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 en  input  1  count enable; when low, the count holds.
REQ-005 up  input  1  direction; 1 = count up, 0 = count down.
REQ-006 load  input  1  synchronous parallel-load strobe.
REQ-007 load_val  input  WIDTH  value to load.
REQ-008 max_val  input  WIDTH  terminal value; the count range is 0..max_val inclusive.
REQ-009 count  output  WIDTH  registered current count.
REQ-010 tc  output  1  combinational terminal count: en & ~load & ((up & count>=max_val) | (~up & count==0)).
REQ-011 wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap edge.

Function
REQ-012 Priority at each posedge: rst > load > en > hold.
REQ-013 load=1: count <= min(load_val, max_val); wrap <= 0; en and up are ignored.
REQ-014 en=1, up=1: count <= 0 if count >= max_val, else count+1.
REQ-015 en=1, up=0: count <= max_val if count == 0, else count-1.
REQ-016 en=0, load=0: count holds; wrap <= 0.
REQ-017 wrap <= 1 exactly when the edge took a REQ-014 or REQ-015 wrap branch; otherwise wrap <= 0.
REQ-018 Latency: count reflects the inputs one clock after the edge samples them; tc has zero latency; wrap has one cycle of latency.
REQ-019 max_val=0: count stays 0; with en=1, tc=1 and wrap=1 every cycle.
REQ-020 max_val lowered below count mid-run: counting up wraps to 0 on the next enabled edge (wrap=1); counting down decrements normally until it reaches 0.
REQ-021 max_val = 2^WIDTH-1 gives a natural binary wrap with no special casing.
REQ-022 A direction change takes effect on the same edge that samples it; there is no dead cycle.
REQ-023 Next-state is formed as a toggle vector t = count ^ next_count; each count bit changes only through its toggle input.

Reset
REQ-024 rst=1 at a posedge: count <= 0 and wrap <= 0, regardless of en, load, up, max_val.
REQ-025 Reset mid-count or during load discards the operation; counting resumes from 0 on the first edge with rst=0.
REQ-026 Before the first reset edge, count is undefined; no X propagates once rst has been sampled high.
REQ-027 tc is combinational, so it follows REQ-010 immediately after reset (e.g. 1 if up=0 and en=1).

Structure
REQ-028 Shared package holds WIDTH_DEFAULT=4 and direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-029 One sub-module: t_flipflop, instantiated WIDTH times (one per count bit) with toggle=t[i] and rst shared; q drives count[i]; q_bar is unused.
REQ-030 Next-count, clamp and wrap-detect logic stays in mod_n_tcounter as one combinational block; there are no latches.
REQ-031 Target size is 120-250 lines of RTL; no asynchronous logic.

Verification
REQ-032 Up-count sequence: rst=1 for 1 cycle, then en=1, up=1, max_val=5 for 8 edges -> count 1,2,3,4,5,0,1,2; wrap=1 only the cycle after count 5->0; tc=1 while count=5.
REQ-033 Down-count sequence: after reset, up=0, en=1, max_val=9 -> count 9,8,7; wrap pulses on the 0->9 edge; tc=1 while count=0.
REQ-034 Load clamp: load=1, load_val=12, max_val=7, en=1 -> count=7, wrap=0; next edge with load=0, up=1 -> count=0, wrap=1.
REQ-035 Reset mid-operation: count=3 counting up, assert rst together with load=1, load_val=6 -> count=0, wrap=0; release rst -> 1,2,...
REQ-036 Boundary cases: max_val=0 with en=1 -> count stays 0, tc=1 and wrap=1 every cycle; max_val=15 (WIDTH=4) up from 14 -> 15, 0 with wrap.
REQ-037 Scoreboard: randomised en/up/load/max_val for 2000 cycles checked against a behavioural model; count <= max_val whenever the last load or wrap is more recent than any max_val decrease.

Source files
------------

// File: rtl/mod_n_tcounter_pkg.sv
// Shared constants for the modulo-N toggle-flop counter.
package mod_n_tcounter_pkg;
    localparam int   WIDTH_DEFAULT = 4;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;
endpackage

// File: rtl/mod_n_tcounter_t_flipflop.sv
// Single T flip-flop with synchronous active-high reset; one per counter bit.
module t_flipflop (
    input  logic clk,
    input  logic rst,
    input  logic toggle,
    output logic q,
    output logic q_bar
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ toggle;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
endmodule

// File: rtl/mod_n_tcounter.sv
// Up/down counter over 0..max_val built from T flip-flops, with parallel
// load clamped to max_val, combinational terminal count and a wrap pulse.
module mod_n_tcounter
    import mod_n_tcounter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] unused_q_bar;
    logic             wrap_d;
    logic             wrap_q;

    // Reset lives in the flops themselves, so this block only sees load/en/hold.
    always_comb begin
        next_count = count;
        wrap_d     = 1'b0;
        if (load) begin
            next_count = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (count >= max_val) begin
                    next_count = '0;
                    wrap_d     = 1'b1;
                end else begin
                    next_count = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    next_count = max_val;
                    wrap_d     = 1'b1;
                end else begin
                    next_count = count - WIDTH'(1);
                end
            end
        end
        t = count ^ next_count;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_flipflop u_tff (
            .clk    (clk),
            .rst    (rst),
            .toggle (t[i]),
            .q      (count[i]),
            .q_bar  (unused_q_bar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_d;
    end

    assign wrap = wrap_q;
    assign tc   = en & ~load & ((up & (count >= max_val)) | (~up & (count == '0)));
endmodule

// File: tb/tb_mod_n_tcounter.sv
// Directed and randomised checks of mod_n_tcounter against a scoreboard model.
module tb_mod_n_tcounter;
    import mod_n_tcounter_pkg::*;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, up, load;
    logic [W-1:0] load_val, max_val;
    logic [W-1:0] count;
    logic         tc, wrap;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         wr;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_count;
    bit           m_valid  = 0;
    bit           bound_ok = 0;
    int           n_vec    = 0;
    int           n_err    = 0;

    mod_n_tcounter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check tc, push the expected post-edge state,
    // then pop and compare after the edge.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [W-1:0] lv, input logic [W-1:0] mv);
        logic [W-1:0] prev_max;
        logic         exp_tc;
        exp_t         x, got;
        prev_max = max_val;
        rst = r; en = e; up = u; load = l; load_val = lv; max_val = mv;
        #1;
        if (m_valid) begin
            exp_tc = e & ~l & ((u & (m_count >= mv)) | (~u & (m_count == 0)));
            check("tc", {31'd0, tc}, {31'd0, exp_tc});
        end
        if (r) begin
            x.cnt = 0; x.wr = 0;
        end else if (l) begin
            x.cnt = (lv > mv) ? mv : lv; x.wr = 0;
        end else if (e && u) begin
            if (m_count >= mv) begin x.cnt = 0; x.wr = 1; end
            else begin x.cnt = m_count + 1'b1; x.wr = 0; end
        end else if (e) begin
            if (m_count == 0) begin x.cnt = mv; x.wr = 1; end
            else begin x.cnt = m_count - 1'b1; x.wr = 0; end
        end else begin
            x.cnt = m_count; x.wr = 0;
        end
        sb.push_back(x);
        if (mv < prev_max) bound_ok = 0;
        if (r || l || x.wr) bound_ok = 1;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            got = sb.pop_front();
            check("count", {28'd0, count}, {28'd0, got.cnt});
            check("wrap", {31'd0, wrap}, {31'd0, got.wr});
            m_count = got.cnt;
            m_valid = 1;
        end
        if (bound_ok) check("bound", {31'd0, count <= max_val}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] up_seq [8];
        logic [W-1:0] dn_seq [3];
        up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2};
        dn_seq = '{4'd9, 4'd8, 4'd7};
        max_val = 0;

        // reset state
        step(1, 1, 1, 1, 4'd6, 4'd5);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_wrap", {31'd0, wrap}, 32'd0);

        // up-count 0..5 with wrap
        for (int i = 0; i < 8; i++) begin
            step(0, 1, DIR_UP, 0, 4'd0, 4'd5);
            check("up_seq", {28'd0, count}, {28'd0, up_seq[i]});
            check("up_wrap", {31'd0, wrap}, (i == 5) ? 32'd1 : 32'd0);
        end

        // down-count from 0 wraps to max_val
        step(1, 0, 0, 0, 4'd0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, DIR_DOWN, 0, 4'd0, 4'd9);
            check("dn_seq", {28'd0, count}, {28'd0, dn_seq[i]});
            check("dn_wrap", {31'd0, wrap}, (i == 0) ? 32'd1 : 32'd0);
        end

        // load clamp then wrap from max
        step(0, 1, DIR_UP, 1, 4'd12, 4'd7);
        check("load_clamp", {28'd0, count}, 32'd7);
        step(0, 1, DIR_UP, 0, 4'd0, 4'd7);
        check("load_wrap", {27'd0, count, wrap}, 32'd1);

        // reset during load and mid-count
        step(1, 0, 0, 0, 4'd0, 4'd9);
        repeat (3) step(0, 1, DIR_UP, 0, 4'd0, 4'd9);
        step(1, 1, DIR_UP, 1, 4'd6, 4'd9);
        check("rst_mid", {27'd0, count, wrap}, 32'd0);
        step(0, 1, DIR_UP, 0, 4'd0, 4'd9);
        check("rst_resume", {28'd0, count}, 32'd1);

        // max_val = 0: wrap and tc every cycle, both directions
        repeat (3) begin
            step(0, 1, DIR_UP, 0, 4'd0, 4'd0);
            check("max0", {27'd0, count, wrap}, 32'd1);
        end
        repeat (2) step(0, 1, DIR_DOWN, 0, 4'd0, 4'd0);

        // full-range binary wrap, and tc straight after reset counting down
        step(0, 0, 0, 1, 4'd14, 4'd15);
        step(0, 1, DIR_UP, 0, 4'd0, 4'd15);
        check("full_15", {28'd0, count}, 32'd15);
        step(0, 1, DIR_UP, 0, 4'd0, 4'd15);
        check("full_wrap", {27'd0, count, wrap}, 32'd1);
        step(1, 1, DIR_DOWN, 0, 4'd0, 4'd15);
        step(0, 1, DIR_DOWN, 0, 4'd0, 4'd15);
        check("dn_after_rst", {28'd0, count}, 32'd15);

        // randomised traffic
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] mv;
            mv = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 15)) : max_val;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 W'($urandom_range(0, 15)), mv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
